// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder parameters and scheduler FSM encoding.
// Group and step widths are derived here so every block agrees on address layout.
package viterbi_pkg;

    localparam int NUM_STATES = 64;
    localparam int PAR        = 4;
    localparam int TB_LEN     = 32;

    localparam int NGRP   = NUM_STATES / 2 / PAR;
    localparam int GRP_W  = $clog2(NGRP);
    localparam int STEP_W = $clog2(TB_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_READY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_TBWAIT = 3'd4
    } state_t;

endpackage

// File: rtl/acs_grp_counter.sv
// Butterfly group counter: sweeps 0..NGRP-1 while enabled and flags the last group.
// Shared by metric initialisation and by each ACS step.
module acs_grp_counter
    import viterbi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [GRP_W-1:0] grp_o,
    output logic             tc_o
);

    logic [GRP_W-1:0] grp_q;
    logic [GRP_W-1:0] grp_d;

    assign tc_o  = (grp_q == GRP_W'(NGRP - 1));
    assign grp_o = grp_q;

    always_comb begin
        grp_d = grp_q;
        if (clr_i) begin
            grp_d = '0;
        end else if (en_i) begin
            grp_d = tc_o ? '0 : grp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_q <= '0;
        end else begin
            grp_q <= grp_d;
        end
    end

endmodule

// File: rtl/acs_scheduler.sv
// Viterbi ACS scheduler: sweeps PAR-wide butterfly groups over every trellis state per symbol,
// ping-pongs path-metric banks, schedules normalisation and kicks traceback every TB_LEN steps.
module acs_scheduler
    import viterbi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    sym_valid,
    input  logic [1:0]              sym_in,
    output logic                    sym_ready,
    output logic                    acs_en,
    output logic [1:0]              acs_rx_pair,
    output logic [GRP_W-1:0]        acs_grp,
    output logic                    pm_init,
    output logic                    pm_bank,
    output logic                    norm_en,
    input  logic                    ovf_in,
    output logic                    dec_wr_en,
    output logic [STEP_W+GRP_W-1:0] dec_wr_addr,
    output logic                    tb_start,
    input  logic                    tb_busy,
    output state_t                  dbg_state
);

    // Symbol handshake: a symbol transfers on a rising edge where sym_valid && sym_ready;
    // the source holds sym_in/sym_valid until then, and sym_valid is ignored otherwise.

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        rx_q, rx_d;
    logic              acc_q, acc_d;
    logic              norm_q, norm_d;
    logic              bank_q, bank_d;
    logic              tb_start_q, tb_start_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [GRP_W-1:0]  grp;
    logic              grp_tc;

    acs_grp_counter u_grp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .grp_o (grp),
        .tc_o  (grp_tc)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        rx_d       = rx_q;
        acc_d      = acc_q;
        norm_d     = norm_q;
        bank_d     = bank_q;
        tb_start_d = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        if (frame_start) begin
            // Abort discards the partial step: no bank toggle, no step advance.
            state_d = ST_INIT;
            cnt_clr = 1'b1;
            acc_d   = 1'b0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_INIT: begin
                    cnt_en = 1'b1;
                    if (grp_tc) begin
                        bank_d  = ~bank_q;
                        step_d  = '0;
                        norm_d  = 1'b0;
                        acc_d   = 1'b0;
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (sym_valid) begin
                        rx_d    = sym_in;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_en = 1'b1;
                    acc_d  = acc_q | ovf_in;
                    if (grp_tc) begin
                        bank_d  = ~bank_q;
                        norm_d  = acc_q | ovf_in;
                        acc_d   = 1'b0;
                        step_d  = step_q + 1'b1;
                        state_d = ST_READY;
                        if (step_q == STEP_W'(TB_LEN - 1)) begin
                            if (tb_busy) begin
                                state_d = ST_TBWAIT;
                            end else begin
                                tb_start_d = 1'b1;
                            end
                        end
                    end
                end
                ST_TBWAIT: begin
                    if (!tb_busy) begin
                        tb_start_d = 1'b1;
                        state_d    = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            rx_q       <= '0;
            acc_q      <= 1'b0;
            norm_q     <= 1'b0;
            bank_q     <= 1'b0;
            tb_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rx_q       <= rx_d;
            acc_q      <= acc_d;
            norm_q     <= norm_d;
            bank_q     <= bank_d;
            tb_start_q <= tb_start_d;
        end
    end

    assign sym_ready   = (state_q == ST_READY);
    assign acs_en      = (state_q == ST_RUN);
    assign pm_init     = (state_q == ST_INIT);
    assign acs_rx_pair = rx_q;
    assign acs_grp     = grp;
    assign pm_bank     = bank_q;
    assign norm_en     = norm_q;
    assign dec_wr_en   = acs_en;
    assign dec_wr_addr = {step_q, grp};
    assign tb_start    = tb_start_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler: directed symbol steps with a scoreboard of expected per-group
// ACS outputs, plus direct checks of init, normalisation, traceback and abort behaviour.
module tb_acs_scheduler;
    import viterbi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_in = 2'b00;
    logic        ovf_in = 1'b0;
    logic        tb_busy = 1'b0;

    logic                    sym_ready;
    logic                    acs_en;
    logic [1:0]              acs_rx_pair;
    logic [GRP_W-1:0]        acs_grp;
    logic                    pm_init;
    logic                    pm_bank;
    logic                    norm_en;
    logic                    dec_wr_en;
    logic [STEP_W+GRP_W-1:0] dec_wr_addr;
    logic                    tb_start;
    state_t                  dbg_state;

    acs_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .sym_valid   (sym_valid),
        .sym_in      (sym_in),
        .sym_ready   (sym_ready),
        .acs_en      (acs_en),
        .acs_rx_pair (acs_rx_pair),
        .acs_grp     (acs_grp),
        .pm_init     (pm_init),
        .pm_bank     (pm_bank),
        .norm_en     (norm_en),
        .ovf_in      (ovf_in),
        .dec_wr_en   (dec_wr_en),
        .dec_wr_addr (dec_wr_addr),
        .tb_start    (tb_start),
        .tb_busy     (tb_busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tb_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    // reference model of the step the scheduler should compute next
    logic [4:0]  m_step;
    logic        m_bank;
    logic        m_norm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // scoreboard monitor: each ACS cycle pops one expected {rx, addr, grp, norm, bank, wr_en}
    always @(negedge clk) begin
        if (tb_start === 1'b1) tb_cnt++;
        if (acs_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_acs_en", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("acs_step", {acs_rx_pair, dec_wr_addr, acs_grp, norm_en, pm_bank, dec_wr_en}, mon_e);
            end
        end
    end

    task automatic do_init;
        logic old_bank;
        logic new_bank;
        old_bank = m_bank;
        new_bank = ~old_bank;
        sym_valid = 1'b0;
        ovf_in = 1'b0;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            chk("init_pm_init", pm_init, 1);
            chk("init_grp", acs_grp, g);
            chk("init_acs_en", acs_en, 0);
            chk("init_ready", sym_ready, 0);
            chk("init_bank_hold", pm_bank, old_bank);
            tick;
        end
        chk("init_done_pm_init", pm_init, 0);
        chk("init_bank_toggle", pm_bank, new_bank);
        chk("init_ready_after", sym_ready, 1);
        chk("init_norm", norm_en, 0);
        m_bank = new_bank;
        m_step = '0;
        m_norm = 1'b0;
    endtask

    // driver: one symbol step; stop_grp >= 0 returns while the DUT is on that group
    task automatic send_sym(input logic [1:0] s, input int ovf_grp, input int stop_grp);
        int   t;
        logic was_last;
        logic [2:0] g3;
        logic exp_rdy;
        logic exp_tbs;
        t = 0;
        while (sym_ready !== 1'b1 && t < 50) begin
            tick;
            t++;
        end
        if (sym_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        sym_valid = 1'b1;
        sym_in = s;
        for (int g = 0; g < NGRP; g++) begin
            g3 = g[2:0];
            if (stop_grp < 0 || g <= stop_grp)
                exp_q.push_back({s, m_step, g3, g3, m_norm, m_bank, 1'b1});
        end
        tick;
        for (int g = 0; g < NGRP; g++) begin
            // source drives a different symbol mid-step; it must be ignored
            sym_valid = (g < NGRP - 1);
            sym_in = ~s;
            ovf_in = (g == ovf_grp);
            if (g == stop_grp) begin
                ovf_in = 1'b0;
                sym_valid = 1'b0;
                return;
            end
            tick;
        end
        ovf_in = 1'b0;
        sym_valid = 1'b0;
        was_last = (m_step == 5'd31);
        m_bank = ~m_bank;
        m_norm = (ovf_grp >= 0);
        m_step = m_step + 5'd1;
        exp_rdy = !(was_last && tb_busy);
        exp_tbs = was_last && !tb_busy;
        chk("post_acs_en", acs_en, 0);
        chk("post_ready", sym_ready, exp_rdy);
        chk("post_tb_start", tb_start, exp_tbs);
        chk("post_bank", pm_bank, m_bank);
        chk("post_norm", norm_en, m_norm);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sym_ready"}, sym_ready, 0);
        chk({tag, "_acs_en"}, acs_en, 0);
        chk({tag, "_pm_init"}, pm_init, 0);
        chk({tag, "_pm_bank"}, pm_bank, 0);
        chk({tag, "_norm_en"}, norm_en, 0);
        chk({tag, "_tb_start"}, tb_start, 0);
        chk({tag, "_dec_wr_en"}, dec_wr_en, 0);
        chk({tag, "_rx_pair"}, acs_rx_pair, 0);
        chk({tag, "_grp"}, acs_grp, 0);
        chk({tag, "_addr"}, dec_wr_addr, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_step = '0;
        m_bank = 1'b0;
        m_norm = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick;
        chk("idle_no_ready", sym_ready, 0);
        chk("idle_state", dbg_state, ST_IDLE);

        // init sweep, then two back-to-back steps
        do_init;
        send_sym(2'b11, -1, -1);
        send_sym(2'b01, -1, -1);

        // overflow on group 5 of step 3 -> normalise step 4 only
        send_sym(2'b10, -1, -1);
        send_sym(2'b00, 5, -1);
        send_sym(2'b01, -1, -1);
        send_sym(2'b11, -1, -1);

        // finish first traceback window with traceback idle
        for (int i = 6; i < 32; i++) send_sym(i[1:0], -1, -1);
        chk("tb_cnt_window1", tb_cnt, 1);

        // second window: traceback busy at window end
        for (int i = 0; i < 31; i++) send_sym(i[1:0], -1, -1);
        tb_busy = 1'b1;
        send_sym(2'b10, -1, -1);
        for (int i = 0; i < 10; i++) begin
            chk("tbwait_state", dbg_state, ST_TBWAIT);
            chk("tbwait_ready", sym_ready, 0);
            chk("tbwait_tb_start", tb_start, 0);
            tick;
        end
        tb_busy = 1'b0;
        tick;
        chk("tbwait_release_pulse", tb_start, 1);
        chk("tbwait_release_ready", sym_ready, 1);
        tick;
        chk("tb_start_one_cycle", tb_start, 0);
        chk("tb_cnt_window2", tb_cnt, 2);
        send_sym(2'b01, -1, -1);

        // frame_start abort at group 3
        send_sym(2'b11, -1, 3);
        do_init;
        send_sym(2'b01, -1, -1);

        // reset mid-step
        send_sym(2'b10, -1, 4);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        m_bank = 1'b0;
        m_step = '0;
        m_norm = 1'b0;
        chk_all_zero("midrst");
        repeat (4) tick;
        chk("midrst_idle_ready", sym_ready, 0);
        chk("midrst_idle_state", dbg_state, ST_IDLE);
        do_init;
        send_sym(2'b00, -1, -1);

        tick;
        chk("queue_empty", exp_q.size(), 0);
        chk("tb_cnt_final", tb_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
